// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hamming_pkg
// Brief   : Shared types and position helpers for the serial SECDED decoder.
// Revision: 1.0
// ============================================================================
package hamming_pkg;

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    CHECK = 2'd1,
    SEND  = 2'd2
  } state_t;

  function automatic int N_OF(input int r);
    return 1 << r;
  endfunction

  function automatic int K_OF(input int r);
    return (1 << r) - r - 1;
  endfunction

  function automatic logic is_pow2(input int pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Powers of two are never adjacent above 2, so skipping one is enough.
  function automatic int next_data_pos(input int pos);
    return is_pow2(pos + 1) ? pos + 2 : pos + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_secded_rx_if.sv
`default_nettype none
// ============================================================================
// Module  : hamming_secded_rx_if
// Brief   : Codeword input, data output and status bundle of the decoder.
// Revision: 1.0
// ============================================================================
interface hamming_secded_rx_if #(
  parameter int R = 4
) ();
  logic         in_valid;
  logic         in_bit;
  logic         in_ready;
  logic         out_valid;
  logic         out_bit;
  logic         out_ready;
  logic         blk_done;
  logic         err_corr;
  logic         err_double;
  logic [R-1:0] err_pos;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_bit, blk_done, err_corr, err_double, err_pos
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_bit, blk_done, err_corr, err_double, err_pos
  );
endinterface
`default_nettype wire

// File: rtl/hamming_syndrome_acc.sv
`default_nettype none
// ============================================================================
// Module  : hamming_syndrome_acc
// Brief   : Position counter with running syndrome and overall parity.
// Revision: 1.0
// ============================================================================
module hamming_syndrome_acc #(
  parameter int R = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_en,
  input  wire logic         i_clr,
  input  wire logic         i_bit,
  output logic [R-1:0]      o_cnt,
  output logic [R-1:0]      o_syn,
  output logic              o_par,
  output logic              o_last
);

  logic [R-1:0] r_cnt;
  logic [R-1:0] r_syn;
  logic         r_par;

  // The counter wraps to zero naturally after position N-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_syn <= '0;
      r_par <= 1'b0;
    end else if (i_clr) begin
      r_syn <= '0;
      r_par <= 1'b0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
      if (i_bit) begin
        r_syn <= r_syn ^ r_cnt;
        r_par <= ~r_par;
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_syn  = r_syn;
  assign o_par  = r_par;
  assign o_last = i_en & (&r_cnt);

endmodule
`default_nettype wire

// File: rtl/hamming_secded_rx.sv
`default_nettype none
// ============================================================================
// Module  : hamming_secded_rx
// Brief   : Serial extended-Hamming block decoder with serial data output.
// Revision: 1.0
// ============================================================================
module hamming_secded_rx
  import hamming_pkg::*;
#(
  parameter int R       = 4,
  parameter bit CORRECT = 1'b1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  hamming_secded_rx_if.slave bus
);

  localparam int c_n = N_OF(R);

  state_t       r_state;
  state_t       w_next;
  logic [c_n-1:0] r_buf;
  logic [R-1:0] r_dpos;
  logic         r_blk_done;
  logic         r_err_corr;
  logic         r_err_double;
  logic [R-1:0] r_err_pos;

  logic         w_in_ready;
  logic         w_out_valid;
  logic         w_accept;
  logic         w_hs;
  logic         w_last_hs;
  logic [R-1:0] w_cnt;
  logic [R-1:0] w_syn;
  logic         w_par;
  logic         w_last;

  assign w_accept  = (r_state == RECV) & bus.in_valid;
  assign w_hs      = (r_state == SEND) & bus.out_ready;
  assign w_last_hs = w_hs & (r_dpos == R'(c_n - 1));

  hamming_syndrome_acc #(.R(R)) u_acc (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_accept),
    .i_clr  (r_state == CHECK),
    .i_bit  (bus.in_bit),
    .o_cnt  (w_cnt),
    .o_syn  (w_syn),
    .o_par  (w_par),
    .o_last (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RECV;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      RECV: begin
        w_in_ready = 1'b1;
        if (w_last) w_next = CHECK;
      end
      CHECK: w_next = SEND;
      SEND: begin
        w_out_valid = 1'b1;
        if (w_last_hs) w_next = RECV;
      end
      default: w_next = RECV;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf        <= '0;
      r_dpos       <= R'(3);
      r_blk_done   <= 1'b0;
      r_err_corr   <= 1'b0;
      r_err_double <= 1'b0;
      r_err_pos    <= '0;
    end else begin
      r_blk_done <= w_last_hs;
      if (w_accept) r_buf[w_cnt] <= bus.in_bit;
      if (r_state == CHECK) begin
        // Odd parity means one flip; the syndrome names it (0 = overall parity bit).
        if (w_par) begin
          r_err_corr   <= 1'b1;
          r_err_double <= 1'b0;
          r_err_pos    <= w_syn;
          if (CORRECT) r_buf[w_syn] <= ~r_buf[w_syn];
        end else if (w_syn != '0) begin
          r_err_corr   <= 1'b0;
          r_err_double <= 1'b1;
          r_err_pos    <= '0;
        end else begin
          r_err_corr   <= 1'b0;
          r_err_double <= 1'b0;
          r_err_pos    <= '0;
        end
      end
      if (w_hs) r_dpos <= w_last_hs ? R'(3) : R'(next_data_pos(int'(r_dpos)));
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_bit    = (r_state == SEND) ? r_buf[r_dpos] : 1'b0;
  assign bus.blk_done   = r_blk_done;
  assign bus.err_corr   = r_err_corr;
  assign bus.err_double = r_err_double;
  assign bus.err_pos    = r_err_pos;

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_hamming_secded_rx
// Brief   : Directed and random block bench for the serial SECDED decoder.
// Revision: 1.0
// ============================================================================
module tb_hamming_secded_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int   sel = 0;
  logic tv = 1'b0, tbit = 1'b0, tr = 1'b0;
  int   n_tests = 0, n_fail = 0;

  hamming_secded_rx_if #(.R(4)) ifa ();
  hamming_secded_rx_if #(.R(4)) ifb ();
  hamming_secded_rx_if #(.R(5)) ifc ();

  assign ifa.in_valid  = tv && (sel == 0);
  assign ifa.in_bit    = tbit;
  assign ifa.out_ready = tr && (sel == 0);
  assign ifb.in_valid  = tv && (sel == 0);
  assign ifb.in_bit    = tbit;
  assign ifb.out_ready = tr && (sel == 0);
  assign ifc.in_valid  = tv && (sel == 1);
  assign ifc.in_bit    = tbit;
  assign ifc.out_ready = tr && (sel == 1);

  hamming_secded_rx #(.R(4), .CORRECT(1'b1)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  hamming_secded_rx #(.R(4), .CORRECT(1'b0)) u_b (.clk(clk), .rst(rst), .bus(ifb));
  hamming_secded_rx #(.R(5), .CORRECT(1'b1)) u_c (.clk(clk), .rst(rst), .bus(ifc));

  logic        w_ir, w_ov, w_ob, w_bd, w_ec, w_ed;
  logic [63:0] w_ep;
  assign w_ir = (sel == 1) ? ifc.in_ready   : ifa.in_ready;
  assign w_ov = (sel == 1) ? ifc.out_valid  : ifa.out_valid;
  assign w_ob = (sel == 1) ? ifc.out_bit    : ifa.out_bit;
  assign w_bd = (sel == 1) ? ifc.blk_done   : ifa.blk_done;
  assign w_ec = (sel == 1) ? ifc.err_corr   : ifa.err_corr;
  assign w_ed = (sel == 1) ? ifc.err_double : ifa.err_double;
  assign w_ep = (sel == 1) ? 64'(ifc.err_pos) : 64'(ifa.err_pos);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: data in non-power-of-two slots, parity bit 2^i covers
  // every position with bit i set, position 0 makes the whole word even.
  function automatic logic [63:0] encode(input logic [63:0] d, input int r);
    int n, j;
    logic [63:0] cw;
    logic p;
    n = 1 << r; j = 0; cw = '0;
    for (int q = 3; q < n; q++)
      if ((q & (q - 1)) != 0) begin cw[q] = d[j]; j++; end
    for (int i = 0; i < r; i++) begin
      p = 1'b0;
      for (int q = 1; q < n; q++)
        if (((q >> i) & 1) == 1 && q != (1 << i)) p = p ^ cw[q];
      cw[1 << i] = p;
    end
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic logic [63:0] extract(input logic [63:0] cw, input int r);
    int n, j;
    logic [63:0] d;
    n = 1 << r; j = 0; d = '0;
    for (int q = 3; q < n; q++)
      if ((q & (q - 1)) != 0) begin d[j] = cw[q]; j++; end
    return d;
  endfunction

  task automatic send_block(input logic [63:0] cw, input int n, input bit gaps, input string tag);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(negedge clk); tv = 1'b0; end
      @(negedge clk); tv = 1'b1; tbit = cw[i];
    end
    @(negedge clk);
    chk({tag, "_check_in_ready"}, w_ir, 0);
    chk({tag, "_check_out_valid"}, w_ov, 0);
    tv = 1'b1; tbit = 1'b1;
  endtask

  task automatic collect(input int k, input int stall_at, input bit rnd, input string tag,
                         output logic [63:0] da, output logic [63:0] db, output int cyc);
    int got, guard, stall_left;
    logic held;
    da = '0; db = '0; cyc = 0; got = 0; guard = 0; stall_left = 5; held = 1'b0;
    @(negedge clk);
    tv = 1'b0; tbit = 1'b0;
    chk({tag, "_latency_out_valid"}, w_ov, 1);
    while (got < k && guard < 1000) begin
      if (stall_at == got && stall_left > 0) begin
        if (stall_left == 5) held = w_ob;
        else begin
          chk({tag, "_stall_out_bit"}, w_ob, held);
          chk({tag, "_stall_in_ready"}, w_ir, 0);
        end
        tr = 1'b0; stall_left--;
      end else begin
        tr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (w_ov) begin
        cyc++;
        if (tr) begin da[got] = w_ob; db[got] = ifb.out_bit; got++; end
      end
      @(negedge clk); guard++;
    end
    chk({tag, "_bits_sent"}, got, k);
    chk({tag, "_blk_done_pulse"}, w_bd, 1);
    chk({tag, "_out_valid_drop"}, w_ov, 0);
    chk({tag, "_in_ready_back"}, w_ir, 1);
    tr = 1'b0;
    @(negedge clk);
    chk({tag, "_blk_done_single"}, w_bd, 0);
  endtask

  task automatic run_block(input int s, input int r, input logic [63:0] d, input int e1, input int e2,
                           input bit gaps, input int stall_at, input bit rnd, input string tag);
    int n, k, nerr, cyc, epos;
    logic [63:0] cw, rxw, da, db, expa, expb, dm;
    sel = s; n = 1 << r; k = n - r - 1; nerr = 0; epos = 0;
    dm = (64'd1 << k) - 64'd1;
    cw = encode(d & dm, r); rxw = cw;
    if (e1 >= 0) begin rxw[e1] = ~rxw[e1]; nerr++; epos = e1; end
    if (e2 >= 0) begin rxw[e2] = ~rxw[e2]; nerr++; epos = e2; end
    send_block(rxw, n, gaps, tag);
    collect(k, stall_at, rnd, tag, da, db, cyc);
    expb = extract(rxw, r);
    expa = (nerr <= 1) ? (d & dm) : expb;
    chk({tag, "_data"}, da, expa);
    if (s == 0) chk({tag, "_data_nocorrect"}, db, expb);
    if (!rnd) chk({tag, "_send_cycles"}, cyc, k + ((stall_at >= 0) ? 5 : 0));
    chk({tag, "_err_corr"}, w_ec, (nerr == 1));
    chk({tag, "_err_double"}, w_ed, (nerr == 2));
    chk({tag, "_err_pos"}, w_ep, (nerr == 1) ? epos : 0);
    if (s == 0) chk({tag, "_err_pos_nocorrect"}, 64'(ifb.err_pos), (nerr == 1) ? epos : 0);
  endtask

  initial begin
    int r, ne, e1, e2;
    logic [63:0] d;

    @(negedge clk);
    chk("reset_in_ready", w_ir, 1);
    chk("reset_out_valid", w_ov, 0);
    chk("reset_out_bit", w_ob, 0);
    chk("reset_blk_done", w_bd, 0);
    chk("reset_status", {w_ec, w_ed, w_ep[3:0]}, 0);
    rst = 1'b0;

    run_block(0, 4, 64'd0, -1, -1, 1'b0, -1, 1'b0, "zero");
    run_block(0, 4, 64'd0, 12, -1, 1'b0, -1, 1'b0, "single12");
    run_block(0, 4, 64'd0, 3, 5, 1'b0, -1, 1'b0, "double3_5");
    run_block(0, 4, 64'd0, 0, -1, 1'b0, 4, 1'b0, "single0_stall");

    // Abort a block after 7 bits; status from the previous block must clear.
    sel = 0;
    for (int i = 0; i < 7; i++) begin @(negedge clk); tv = 1'b1; tbit = 1'b1; end
    @(negedge clk); tv = 1'b0; rst = 1'b1;
    #1;
    chk("midrst_in_ready", w_ir, 1);
    chk("midrst_out_valid", w_ov, 0);
    chk("midrst_err_corr", w_ec, 0);
    @(negedge clk); rst = 1'b0;
    run_block(0, 4, 64'b10110100110, -1, -1, 1'b0, -1, 1'b0, "after_rst");

    run_block(1, 5, 64'h2A5_C3F1, 29, -1, 1'b0, -1, 1'b0, "r5_single29");

    for (int t = 0; t < 12; t++) begin
      r = (t < 8) ? 4 : 5;
      d = {$urandom, $urandom};
      ne = $urandom_range(0, 2);
      e1 = (ne >= 1) ? $urandom_range(0, (1 << r) - 1) : -1;
      e2 = -1;
      if (ne == 2) begin
        e2 = $urandom_range(0, (1 << r) - 1);
        while (e2 == e1) e2 = $urandom_range(0, (1 << r) - 1);
      end
      run_block((r == 5) ? 1 : 0, r, d, e1, e2, 1'b1, -1, 1'b1, $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
